fm_demod_seq: RTL and testbench

FM demodulation sequencer that sits between the channel-filter IQ FIFOs and the shared `qarctan` phase core. For each IQ sample it forms the conjugate product of the current and previous samples and hands the real/imag parts to `qarctan` through its input FIFOs. It then collects the returned angle, applies the fixed demod gain, and writes the scaled result to the audio-path FIFO. Exactly one sample is in flight at a time.

---
 rtl/fm_demod_seq.sv | 150 +++++++++++++++
 tb/tb_fm_demod_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_seq.sv
// fm_demod_seq: one-sample-at-a-time FM demod sequencer.
// Forms the conjugate product of the current and previous IQ samples,
// hands it to the shared qarctan core, then scales the returned angle
// by the demod gain and forwards it to the audio FIFO.
module fm_demod_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int GAIN       = 758
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] real_dout,
  input  logic                         real_empty,
  output logic                         real_rd_en,
  input  logic signed [DATA_WIDTH-1:0] imag_dout,
  input  logic                         imag_empty,
  output logic                         imag_rd_en,
  output logic signed [DATA_WIDTH-1:0] atan_r_din,
  input  logic                         atan_r_full,
  output logic                         atan_r_wr_en,
  output logic signed [DATA_WIDTH-1:0] atan_i_din,
  input  logic                         atan_i_full,
  output logic                         atan_i_wr_en,
  input  logic signed [DATA_WIDTH-1:0] atan_dout,
  input  logic                         atan_empty,
  output logic                         atan_rd_en,
  output logic signed [DATA_WIDTH-1:0] out_din,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic                         busy
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [1:0] S_READ  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Bias added to negative products so the arithmetic shift rounds toward zero.
  localparam logic signed [PW-1:0] RND    = PW'((64'd1 << BITS) - 64'd1);
  localparam logic signed [PW-1:0] GAIN_W = PW'(GAIN);

  // Dequantize a full-width product back to BITS fraction, rounding toward zero.
  function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t = x[PW-1] ? (x + RND) : x;
    return DATA_WIDTH'(t >>> BITS);
  endfunction

  logic [1:0]                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] prev_r_q, prev_r_d;
  logic signed [DATA_WIDTH-1:0] prev_i_q, prev_i_d;
  logic signed [DATA_WIDTH-1:0] op_r_q, op_r_d;
  logic signed [DATA_WIDTH-1:0] op_i_q, op_i_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;

  logic signed [PW-1:0]         p_rr, n_ii, p_ri, n_ir, p_gain;
  logic signed [DATA_WIDTH-1:0] conj_r, conj_i, scaled;

  // Conjugate product x * conj(prev) and gain scaling of the returned angle.
  always_comb begin
    p_rr   = PW'(prev_r_q) * PW'(real_dout);
    n_ii   = -(PW'(prev_i_q) * PW'(imag_dout));
    p_ri   = PW'(prev_r_q) * PW'(imag_dout);
    n_ir   = -(PW'(prev_i_q) * PW'(real_dout));
    conj_r = deq(p_rr) - deq(n_ii);
    conj_i = deq(p_ri) + deq(n_ir);
    p_gain = GAIN_W * PW'(atan_dout);
    scaled = deq(p_gain);
  end

  // Sequencer: next state, register loads and FIFO strobes (strobes only when the flag allows).
  always_comb begin
    state_d      = state_q;
    prev_r_d     = prev_r_q;
    prev_i_d     = prev_i_q;
    op_r_d       = op_r_q;
    op_i_d       = op_i_q;
    res_d        = res_q;
    real_rd_en   = 1'b0;
    imag_rd_en   = 1'b0;
    atan_r_wr_en = 1'b0;
    atan_i_wr_en = 1'b0;
    atan_r_din   = '0;
    atan_i_din   = '0;
    atan_rd_en   = 1'b0;
    out_wr_en    = 1'b0;
    out_din      = '0;
    case (state_q)
      S_READ: begin
        if (!real_empty && !imag_empty) begin
          real_rd_en = 1'b1;
          imag_rd_en = 1'b1;
          op_r_d     = conj_r;
          op_i_d     = conj_i;
          prev_r_d   = real_dout;
          prev_i_d   = imag_dout;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!atan_r_full && !atan_i_full) begin
          atan_r_wr_en = 1'b1;
          atan_i_wr_en = 1'b1;
          atan_r_din   = op_r_q;
          atan_i_din   = op_i_q;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!atan_empty) begin
          atan_rd_en = 1'b1;
          res_d      = scaled;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          out_din   = res_q;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  // State and datapath registers; reset drops any in-flight sample and clears history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_READ;
      prev_r_q <= '0;
      prev_i_q <= '0;
      op_r_q   <= '0;
      op_i_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_r_q <= prev_r_d;
      prev_i_q <= prev_i_d;
      op_r_q   <= op_r_d;
      op_i_q   <= op_i_d;
      res_q    <= res_d;
    end
  end

  assign busy = (state_q != S_READ);

endmodule

// File: tb/tb_fm_demod_seq.sv
// Self-checking bench for fm_demod_seq: directed test-plan steps followed by
// randomized samples, checked against an arithmetic reference model.
module tb_fm_demod_seq;

  logic               clock;
  logic               reset;
  logic signed [31:0] real_dout, imag_dout, atan_dout;
  logic               real_empty, imag_empty, atan_empty;
  logic               atan_r_full, atan_i_full, out_full;
  logic               real_rd_en, imag_rd_en, atan_r_wr_en, atan_i_wr_en;
  logic               atan_rd_en, out_wr_en, busy;
  logic signed [31:0] atan_r_din, atan_i_din, out_din;

  int checks   = 0;
  int failures = 0;

  // Reference-model history and last observed results.
  int pr_m = 0;
  int pi_m = 0;
  int last_r, last_i, last_o;

  fm_demod_seq #(.DATA_WIDTH(32), .BITS(10), .GAIN(758)) dut (
    .clock(clock), .reset(reset),
    .real_dout(real_dout), .real_empty(real_empty), .real_rd_en(real_rd_en),
    .imag_dout(imag_dout), .imag_empty(imag_empty), .imag_rd_en(imag_rd_en),
    .atan_r_din(atan_r_din), .atan_r_full(atan_r_full), .atan_r_wr_en(atan_r_wr_en),
    .atan_i_din(atan_i_din), .atan_i_full(atan_i_full), .atan_i_wr_en(atan_i_wr_en),
    .atan_dout(atan_dout), .atan_empty(atan_empty), .atan_rd_en(atan_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Fixed-point dequantize: divide by 2^10 rounding toward zero, keep 32 bits.
  function automatic int deq_m(input longint x);
    return int'(x / 64'sd1024);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete sample: pop, issue (with optional stall), wait, output (with optional stall).
  task automatic run_sample(input int xr, input int xi, input int ang,
                            input int r_stall, input int w_dly, input int o_stall);
    int er, ei, eo;
    er   = deq_m(longint'(pr_m) * xr) - deq_m(-(longint'(pi_m) * xi));
    ei   = deq_m(longint'(pr_m) * xi) + deq_m(-(longint'(pi_m) * xr));
    pr_m = xr;
    pi_m = xi;
    eo   = deq_m(longint'(758) * ang);

    @(negedge clock);
    real_dout = xr; imag_dout = xi; real_empty = 1'b0; imag_empty = 1'b0;
    #1;
    chk("pop_real", real_rd_en, 1);
    chk("pop_imag", imag_rd_en, 1);
    chk("idle_busy", busy, 0);

    @(negedge clock);
    real_empty = 1'b1; imag_empty = 1'b1;
    for (int k = 0; k < r_stall; k++) begin
      atan_r_full = (k % 2 == 0);
      atan_i_full = (k % 2 == 1);
      real_empty  = 1'b0; imag_empty = 1'b0;
      #1;
      chk("stall_r_wr", atan_r_wr_en, 0);
      chk("stall_i_wr", atan_i_wr_en, 0);
      chk("stall_nopop", real_rd_en, 0);
      chk("stall_r_din", atan_r_din, 0);
      @(negedge clock);
    end
    atan_r_full = 1'b0; atan_i_full = 1'b0; real_empty = 1'b1; imag_empty = 1'b1;
    #1;
    chk("issue_r_wr", atan_r_wr_en, 1);
    chk("issue_i_wr", atan_i_wr_en, 1);
    chk("issue_r_din", atan_r_din, er);
    chk("issue_i_din", atan_i_din, ei);
    last_r = atan_r_din;
    last_i = atan_i_din;

    @(negedge clock);
    for (int k = 0; k < w_dly; k++) begin
      #1;
      chk("wait_rd", atan_rd_en, 0);
      chk("wait_busy", busy, 1);
      @(negedge clock);
    end
    atan_dout = ang; atan_empty = 1'b0;
    #1;
    chk("atan_pop", atan_rd_en, 1);

    @(negedge clock);
    atan_empty = 1'b1; atan_dout = 0;
    for (int k = 0; k < o_stall; k++) begin
      out_full = 1'b1;
      #1;
      chk("ostall_wr", out_wr_en, 0);
      chk("ostall_din", out_din, 0);
      @(negedge clock);
    end
    out_full = 1'b0;
    #1;
    chk("out_wr", out_wr_en, 1);
    chk("out_din", out_din, eo);
    last_o = out_din;
    $display("txn x=(%0d,%0d) issue=(%0d,%0d) exp=(%0d,%0d) ang=%0d out=%0d exp=%0d",
             xr, xi, last_r, last_i, er, ei, ang, last_o, eo);
  endtask

  initial begin
    reset = 1'b1;
    real_dout = 0; imag_dout = 0; atan_dout = 0;
    real_empty = 1'b1; imag_empty = 1'b1; atan_empty = 1'b1;
    atan_r_full = 1'b0; atan_i_full = 1'b0; out_full = 1'b0;
    #1;
    chk("rst_real_rd", real_rd_en, 0);
    chk("rst_atan_wr", atan_r_wr_en, 0);
    chk("rst_atan_din", atan_r_din, 0);
    chk("rst_out_wr", out_wr_en, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // First sample after reset issues (0,0); the second issues (1024,0).
    run_sample(1024, 0, 804, 0, 0, 0);
    chk("tp_first_r", last_r, 0);
    chk("tp_first_i", last_i, 0);
    chk("tp_gain_pos", last_o, 595);
    run_sample(1024, 0, -804, 0, 2, 0);
    chk("tp_second_r", last_r, 1024);
    chk("tp_second_i", last_i, 0);
    chk("tp_gain_neg", last_o, -595);

    // Quarter-turn rotation.
    run_sample(1024, 0, 0, 0, 0, 0);
    run_sample(0, 1024, 0, 0, 0, 0);
    chk("tp_rot_r", last_r, 0);
    chk("tp_rot_i", last_i, 1024);

    // Negative product rounds toward zero.
    run_sample(-3, 0, 1, 0, 0, 0);
    run_sample(5, 0, -1, 0, 0, 0);
    chk("tp_round_r", last_r, 0);

    // Ten cycles of backpressure on both the issue and output sides.
    run_sample(700, -300, 1500, 10, 3, 10);

    // Reset while waiting on qarctan: strobes and busy drop at once, history cleared.
    @(negedge clock);
    real_dout = 2000; imag_dout = 1000; real_empty = 1'b0; imag_empty = 1'b0;
    pr_m = 2000; pi_m = 1000;
    @(negedge clock);
    real_empty = 1'b1; imag_empty = 1'b1;
    @(negedge clock);
    #1;
    chk("pre_rst_busy", busy, 1);
    atan_dout = 123; atan_empty = 1'b0; reset = 1'b1;
    #1;
    chk("mid_rst_atan_rd", atan_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_wr", out_wr_en, 0);
    chk("mid_rst_issue_wr", atan_r_wr_en, 0);
    @(negedge clock);
    reset = 1'b0; atan_empty = 1'b1; atan_dout = 0;
    pr_m = 0; pi_m = 0;
    run_sample(-4096, 777, 300, 0, 0, 0);
    chk("post_rst_r", last_r, 0);
    chk("post_rst_i", last_i, 0);

    // Randomized samples with random stalls.
    for (int n = 0; n < 24; n++) begin
      int xr, xi, ang;
      if (n % 3 == 0) begin
        xr = int'($urandom);
        xi = int'($urandom);
      end else begin
        xr = int'($urandom_range(0, 8191)) - 4096;
        xi = int'($urandom_range(0, 8191)) - 4096;
      end
      ang = int'($urandom_range(0, 6434)) - 3217;
      run_sample(xr, xi, ang, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
